// File: rtl/mem_access_stage.sv
// MEM stage: issues one data-bus transaction per load/store and builds the write-back result.
// Latency: ALU ops are valid 1 cycle after accept; loads/stores at least 3 cycles after accept.
// Backpressure: mem_allowin held low while a bus transaction is open or WB stalls the held result.
//
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   *_EXE_MEM          - instruction fields from the EXE/MEM registers (exe_to_mem_valid / mem_allowin)
//   ex_int_handle      - exception flush
//   data_*             - SRAM-like data bus (req / addr_ok / data_ok)
//   *_MEM_WB           - write-back result to WB (mem_to_wb_valid / wb_allowin)
module mem_access_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_to_mem_valid,
    output logic        mem_allowin,
    input  logic        MemEn_EXE_MEM,
    input  logic [3:0]  MemWrite_EXE_MEM,
    input  logic [31:0] ALUResult_EXE_MEM,
    input  logic [31:0] MemWdata_EXE_MEM,
    input  logic [1:0]  s_vaddr_EXE_MEM,
    input  logic [2:0]  s_size_EXE_MEM,
    input  logic        LB_EXE_MEM,
    input  logic        LBU_EXE_MEM,
    input  logic        LH_EXE_MEM,
    input  logic        LHU_EXE_MEM,
    input  logic [1:0]  LW_EXE_MEM,
    input  logic [31:0] RegRdata2_EXE_MEM,
    input  logic [4:0]  RegWaddr_EXE_MEM,
    input  logic [3:0]  RegWrite_EXE_MEM,
    input  logic [31:0] PC_EXE_MEM,
    input  logic        ex_int_handle,
    output logic        data_req,
    output logic        data_wr,
    output logic [2:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    input  logic        wb_allowin,
    output logic        mem_to_wb_valid,
    output logic [4:0]  RegWaddr_MEM_WB,
    output logic [3:0]  RegWrite_MEM_WB,
    output logic [31:0] RegWdata_MEM_WB,
    output logic [31:0] PC_MEM_WB
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_REQ   = 2'd1,
        S_RESP  = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e      state_q,    state_d;
    logic        cancel_q,   cancel_d;
    logic        is_store_q, is_store_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [1:0]  svaddr_q,   svaddr_d;
    logic [2:0]  ssize_q,    ssize_d;
    logic        lb_q,       lb_d;
    logic        lbu_q,      lbu_d;
    logic        lh_q,       lh_d;
    logic        lhu_q,      lhu_d;
    logic [1:0]  lw_q,       lw_d;
    logic [31:0] rt_q,       rt_d;
    logic [4:0]  regwaddr_q, regwaddr_d;
    logic [3:0]  regwrite_q, regwrite_d;
    logic [31:0] regwdata_q, regwdata_d;
    logic [31:0] pc_q,       pc_d;

    logic        accept;
    logic        in_req;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign mem_allowin = ~ex_int_handle &
                         ((state_q == S_EMPTY) | ((state_q == S_HOLD) & wb_allowin));
    assign accept      = exe_to_mem_valid & mem_allowin;
    assign in_req      = (state_q == S_REQ);

    // Bus outputs are driven only while a request is outstanding.
    assign data_req   = in_req;
    assign data_wr    = in_req & is_store_q;
    assign data_addr  = !in_req   ? 32'd0 :
                        is_store_q ? {addr_q[31:2], svaddr_q} : {addr_q[31:2], 2'b00};
    assign data_size  = !in_req   ? 3'd0 : (is_store_q ? ssize_q : 3'd2);
    assign data_wdata = (in_req & is_store_q) ? wdata_q : 32'd0;

    assign mem_to_wb_valid = (state_q == S_HOLD);
    assign RegWaddr_MEM_WB = regwaddr_q;
    assign RegWrite_MEM_WB = regwrite_q;
    assign RegWdata_MEM_WB = regwdata_q;
    assign PC_MEM_WB       = pc_q;

    // Load alignment: bus always returns the whole aligned word.
    always_comb begin
        byte_sel  = 8'd0;
        half_sel  = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        load_data = data_rdata;
        case (addr_q[1:0])
            2'd0:    byte_sel = data_rdata[7:0];
            2'd1:    byte_sel = data_rdata[15:8];
            2'd2:    byte_sel = data_rdata[23:16];
            default: byte_sel = data_rdata[31:24];
        endcase
        if (lb_q) begin
            load_data = {{24{byte_sel[7]}}, byte_sel};
        end else if (lbu_q) begin
            load_data = {24'd0, byte_sel};
        end else if (lh_q) begin
            load_data = {{16{half_sel[15]}}, half_sel};
        end else if (lhu_q) begin
            load_data = {16'd0, half_sel};
        end else if (lw_q == 2'b10) begin
            // LWL: high-order bytes come from memory, low-order kept from rt
            case (addr_q[1:0])
                2'd0:    load_data = {data_rdata[7:0],  rt_q[23:0]};
                2'd1:    load_data = {data_rdata[15:0], rt_q[15:0]};
                2'd2:    load_data = {data_rdata[23:0], rt_q[7:0]};
                default: load_data = data_rdata;
            endcase
        end else if (lw_q == 2'b01) begin
            // LWR: low-order bytes come from memory, high-order kept from rt
            case (addr_q[1:0])
                2'd0:    load_data = data_rdata;
                2'd1:    load_data = {rt_q[31:24], data_rdata[31:8]};
                2'd2:    load_data = {rt_q[31:16], data_rdata[31:16]};
                default: load_data = {rt_q[31:8],  data_rdata[31:24]};
            endcase
        end else begin
            load_data = data_rdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        cancel_d   = cancel_q;
        is_store_d = is_store_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        svaddr_d   = svaddr_q;
        ssize_d    = ssize_q;
        lb_d       = lb_q;
        lbu_d      = lbu_q;
        lh_d       = lh_q;
        lhu_d      = lhu_q;
        lw_d       = lw_q;
        rt_d       = rt_q;
        regwaddr_d = regwaddr_q;
        regwrite_d = regwrite_q;
        regwdata_d = regwdata_q;
        pc_d       = pc_q;

        case (state_q)
            S_REQ: begin
                if (data_addr_ok) begin
                    // Once accepted the transaction must be drained even if flushed.
                    state_d  = S_RESP;
                    cancel_d = ex_int_handle;
                end else if (ex_int_handle) begin
                    state_d = S_EMPTY;
                end
            end
            S_RESP: begin
                if (data_data_ok) begin
                    if (cancel_q | ex_int_handle) begin
                        state_d  = S_EMPTY;
                        cancel_d = 1'b0;
                    end else begin
                        state_d    = S_HOLD;
                        regwdata_d = load_data;
                        if (is_store_q) begin
                            regwrite_d = 4'd0;
                        end
                    end
                end else if (ex_int_handle) begin
                    cancel_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (ex_int_handle || wb_allowin) begin
                    state_d = S_EMPTY;
                end
            end
            default: begin
            end
        endcase

        // Accept only happens from EMPTY or a draining HOLD, so it overrides the above.
        if (accept) begin
            state_d    = MemEn_EXE_MEM ? S_REQ : S_HOLD;
            cancel_d   = 1'b0;
            is_store_d = |MemWrite_EXE_MEM;
            addr_d     = ALUResult_EXE_MEM;
            wdata_d    = MemWdata_EXE_MEM;
            svaddr_d   = s_vaddr_EXE_MEM;
            ssize_d    = s_size_EXE_MEM;
            lb_d       = LB_EXE_MEM;
            lbu_d      = LBU_EXE_MEM;
            lh_d       = LH_EXE_MEM;
            lhu_d      = LHU_EXE_MEM;
            lw_d       = LW_EXE_MEM;
            rt_d       = RegRdata2_EXE_MEM;
            regwaddr_d = RegWaddr_EXE_MEM;
            regwrite_d = RegWrite_EXE_MEM;
            regwdata_d = ALUResult_EXE_MEM;
            pc_d       = PC_EXE_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            cancel_q   <= 1'b0;
            is_store_q <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            svaddr_q   <= 2'd0;
            ssize_q    <= 3'd0;
            lb_q       <= 1'b0;
            lbu_q      <= 1'b0;
            lh_q       <= 1'b0;
            lhu_q      <= 1'b0;
            lw_q       <= 2'd0;
            rt_q       <= 32'd0;
            regwaddr_q <= 5'd0;
            regwrite_q <= 4'd0;
            regwdata_q <= 32'd0;
            pc_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            cancel_q   <= cancel_d;
            is_store_q <= is_store_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            svaddr_q   <= svaddr_d;
            ssize_q    <= ssize_d;
            lb_q       <= lb_d;
            lbu_q      <= lbu_d;
            lh_q       <= lh_d;
            lhu_q      <= lhu_d;
            lw_q       <= lw_d;
            rt_q       <= rt_d;
            regwaddr_q <= regwaddr_d;
            regwrite_q <= regwrite_d;
            regwdata_q <= regwdata_d;
            pc_q       <= pc_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: table of single transactions plus stall/flush sequences.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: wb_allowin and bus handshakes are driven explicitly by each sequence.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        exe_to_mem_valid;
    logic        mem_allowin;
    logic        MemEn_EXE_MEM;
    logic [3:0]  MemWrite_EXE_MEM;
    logic [31:0] ALUResult_EXE_MEM;
    logic [31:0] MemWdata_EXE_MEM;
    logic [1:0]  s_vaddr_EXE_MEM;
    logic [2:0]  s_size_EXE_MEM;
    logic        LB_EXE_MEM, LBU_EXE_MEM, LH_EXE_MEM, LHU_EXE_MEM;
    logic [1:0]  LW_EXE_MEM;
    logic [31:0] RegRdata2_EXE_MEM;
    logic [4:0]  RegWaddr_EXE_MEM;
    logic [3:0]  RegWrite_EXE_MEM;
    logic [31:0] PC_EXE_MEM;
    logic        ex_int_handle;
    logic        data_req, data_wr;
    logic [2:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [4:0]  RegWaddr_MEM_WB;
    logic [3:0]  RegWrite_MEM_WB;
    logic [31:0] RegWdata_MEM_WB;
    logic [31:0] PC_MEM_WB;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_stage dut (
        .clk               (clk),
        .rst               (rst),
        .exe_to_mem_valid  (exe_to_mem_valid),
        .mem_allowin       (mem_allowin),
        .MemEn_EXE_MEM     (MemEn_EXE_MEM),
        .MemWrite_EXE_MEM  (MemWrite_EXE_MEM),
        .ALUResult_EXE_MEM (ALUResult_EXE_MEM),
        .MemWdata_EXE_MEM  (MemWdata_EXE_MEM),
        .s_vaddr_EXE_MEM   (s_vaddr_EXE_MEM),
        .s_size_EXE_MEM    (s_size_EXE_MEM),
        .LB_EXE_MEM        (LB_EXE_MEM),
        .LBU_EXE_MEM       (LBU_EXE_MEM),
        .LH_EXE_MEM        (LH_EXE_MEM),
        .LHU_EXE_MEM       (LHU_EXE_MEM),
        .LW_EXE_MEM        (LW_EXE_MEM),
        .RegRdata2_EXE_MEM (RegRdata2_EXE_MEM),
        .RegWaddr_EXE_MEM  (RegWaddr_EXE_MEM),
        .RegWrite_EXE_MEM  (RegWrite_EXE_MEM),
        .PC_EXE_MEM        (PC_EXE_MEM),
        .ex_int_handle     (ex_int_handle),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_addr_ok      (data_addr_ok),
        .data_data_ok      (data_data_ok),
        .data_rdata        (data_rdata),
        .wb_allowin        (wb_allowin),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .RegWaddr_MEM_WB   (RegWaddr_MEM_WB),
        .RegWrite_MEM_WB   (RegWrite_MEM_WB),
        .RegWdata_MEM_WB   (RegWdata_MEM_WB),
        .PC_MEM_WB         (PC_MEM_WB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        memen;
        logic [3:0]  memwrite;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [1:0]  svaddr;
        logic [2:0]  ssize;
        logic [3:0]  ltype;      // {LB, LBU, LH, LHU}
        logic [1:0]  lw;
        logic [31:0] rt;
        logic [31:0] rdata;
        logic [3:0]  regwrite;
        logic [31:0] exp_addr;
        logic [2:0]  exp_size;
        logic        exp_wr;
        logic [31:0] exp_wdata;
        logic        chk_res;
        logic [31:0] exp_res;
        logic [3:0]  exp_regwrite;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vec [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        exe_to_mem_valid  = 1'b0;
        MemEn_EXE_MEM     = 1'b0;
        MemWrite_EXE_MEM  = 4'd0;
        ALUResult_EXE_MEM = 32'd0;
        MemWdata_EXE_MEM  = 32'd0;
        s_vaddr_EXE_MEM   = 2'd0;
        s_size_EXE_MEM    = 3'd0;
        LB_EXE_MEM        = 1'b0;
        LBU_EXE_MEM       = 1'b0;
        LH_EXE_MEM        = 1'b0;
        LHU_EXE_MEM       = 1'b0;
        LW_EXE_MEM        = 2'd0;
        RegRdata2_EXE_MEM = 32'd0;
        RegWaddr_EXE_MEM  = 5'd0;
        RegWrite_EXE_MEM  = 4'd0;
        PC_EXE_MEM        = 32'd0;
        ex_int_handle     = 1'b0;
        data_addr_ok      = 1'b0;
        data_data_ok      = 1'b0;
        data_rdata        = 32'd0;
    endtask

    task automatic drive_instr(input logic memen, input logic [31:0] alu, input logic [3:0] ltype,
                               input logic [1:0] lw, input logic [4:0] waddr, input logic [31:0] pc);
        exe_to_mem_valid  = 1'b1;
        MemEn_EXE_MEM     = memen;
        MemWrite_EXE_MEM  = 4'd0;
        ALUResult_EXE_MEM = alu;
        {LB_EXE_MEM, LBU_EXE_MEM, LH_EXE_MEM, LHU_EXE_MEM} = ltype;
        LW_EXE_MEM        = lw;
        RegWaddr_EXE_MEM  = waddr;
        RegWrite_EXE_MEM  = 4'hF;
        PC_EXE_MEM        = pc;
    endtask

    task automatic run_vec(input int i);
        logic [4:0]  exp_waddr;
        logic [31:0] exp_pc;
        exp_waddr = 5'(i + 1);
        exp_pc    = 32'hBFC0_0000 + 32'(i * 4);
        nxt();
        exe_to_mem_valid  = 1'b1;
        wb_allowin        = 1'b1;
        MemEn_EXE_MEM     = vec[i].memen;
        MemWrite_EXE_MEM  = vec[i].memwrite;
        ALUResult_EXE_MEM = vec[i].alu;
        MemWdata_EXE_MEM  = vec[i].wdata;
        s_vaddr_EXE_MEM   = vec[i].svaddr;
        s_size_EXE_MEM    = vec[i].ssize;
        {LB_EXE_MEM, LBU_EXE_MEM, LH_EXE_MEM, LHU_EXE_MEM} = vec[i].ltype;
        LW_EXE_MEM        = vec[i].lw;
        RegRdata2_EXE_MEM = vec[i].rt;
        RegWaddr_EXE_MEM  = exp_waddr;
        RegWrite_EXE_MEM  = vec[i].regwrite;
        PC_EXE_MEM        = exp_pc;
        smp();
        check($sformatf("v%0d allowin_empty", i), 32'(mem_allowin), 32'd1);
        nxt();
        idle_inputs();
        if (vec[i].memen) begin
            smp();
            check($sformatf("v%0d req", i), 32'(data_req), 32'd1);
            check($sformatf("v%0d addr", i), data_addr, vec[i].exp_addr);
            check($sformatf("v%0d size", i), 32'(data_size), 32'(vec[i].exp_size));
            check($sformatf("v%0d wr", i), 32'(data_wr), 32'(vec[i].exp_wr));
            check($sformatf("v%0d wdata", i), data_wdata, vec[i].exp_wdata);
            check($sformatf("v%0d allowin_req", i), 32'(mem_allowin), 32'd0);
            data_addr_ok = 1'b1;
            nxt();
            data_addr_ok = 1'b0;
            data_data_ok = 1'b1;
            data_rdata   = vec[i].rdata;
            smp();
            check($sformatf("v%0d req_dropped", i), 32'(data_req), 32'd0);
            nxt();
            data_data_ok = 1'b0;
            data_rdata   = 32'd0;
        end
        smp();
        check($sformatf("v%0d valid", i), 32'(mem_to_wb_valid), 32'd1);
        check($sformatf("v%0d req_hold", i), 32'(data_req), 32'd0);
        if (vec[i].chk_res)
            check($sformatf("v%0d wdata_wb", i), RegWdata_MEM_WB, vec[i].exp_res);
        check($sformatf("v%0d regwrite", i), 32'(RegWrite_MEM_WB), 32'(vec[i].exp_regwrite));
        check($sformatf("v%0d waddr", i), 32'(RegWaddr_MEM_WB), 32'(exp_waddr));
        check($sformatf("v%0d pc", i), PC_MEM_WB, exp_pc);
        nxt();
        smp();
        check($sformatf("v%0d valid_drop", i), 32'(mem_to_wb_valid), 32'd0);
    endtask

    initial begin
        //          memen mw     alu           wdata         sv    sz    ltype  lw     rt            rdata         rw     exp_addr      sz    wr    exp_wdata     chk   exp_res       exp_rw
        vec[0]  = '{1'b0, 4'h0, 32'h0000_1234, 32'h0,        2'd0, 3'd0, 4'h0, 2'b00, 32'h0,        32'h0,        4'hF, 32'h0,        3'd0, 1'b0, 32'h0,        1'b1, 32'h0000_1234, 4'hF};
        vec[1]  = '{1'b1, 4'h0, 32'h0000_0103, 32'h0,        2'd0, 3'd0, 4'h8, 2'b00, 32'h0,        32'h80FF_0000, 4'hF, 32'h0000_0100, 3'd2, 1'b0, 32'h0,        1'b1, 32'hFFFF_FF80, 4'hF};
        vec[2]  = '{1'b1, 4'h0, 32'h0000_0103, 32'h0,        2'd0, 3'd0, 4'h4, 2'b00, 32'h0,        32'h80FF_0000, 4'hF, 32'h0000_0100, 3'd2, 1'b0, 32'h0,        1'b1, 32'h0000_0080, 4'hF};
        vec[3]  = '{1'b1, 4'h0, 32'h0000_0102, 32'h0,        2'd0, 3'd0, 4'h2, 2'b00, 32'h0,        32'h80FF_0000, 4'hF, 32'h0000_0100, 3'd2, 1'b0, 32'h0,        1'b1, 32'hFFFF_80FF, 4'hF};
        vec[4]  = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,        2'd0, 3'd0, 4'h1, 2'b00, 32'h0,        32'h1234_8001, 4'hF, 32'h0000_0100, 3'd2, 1'b0, 32'h0,        1'b1, 32'h0000_8001, 4'hF};
        vec[5]  = '{1'b1, 4'h0, 32'h0000_0204, 32'h0,        2'd0, 3'd0, 4'h0, 2'b11, 32'h0,        32'hDEAD_BEEF, 4'hF, 32'h0000_0204, 3'd2, 1'b0, 32'h0,        1'b1, 32'hDEAD_BEEF, 4'hF};
        vec[6]  = '{1'b1, 4'h0, 32'h0000_0201, 32'h0,        2'd0, 3'd0, 4'h0, 2'b10, 32'h1122_3344, 32'hAABB_CCDD, 4'hF, 32'h0000_0200, 3'd2, 1'b0, 32'h0,        1'b1, 32'hCCDD_3344, 4'hF};
        vec[7]  = '{1'b1, 4'h0, 32'h0000_0201, 32'h0,        2'd0, 3'd0, 4'h0, 2'b01, 32'h1122_3344, 32'hAABB_CCDD, 4'hF, 32'h0000_0200, 3'd2, 1'b0, 32'h0,        1'b1, 32'h11AA_BBCC, 4'hF};
        vec[8]  = '{1'b1, 4'h0, 32'h0000_0200, 32'h0,        2'd0, 3'd0, 4'h0, 2'b10, 32'h1122_3344, 32'hAABB_CCDD, 4'hF, 32'h0000_0200, 3'd2, 1'b0, 32'h0,        1'b1, 32'hDD22_3344, 4'hF};
        vec[9]  = '{1'b1, 4'h0, 32'h0000_0203, 32'h0,        2'd0, 3'd0, 4'h0, 2'b01, 32'h1122_3344, 32'hAABB_CCDD, 4'hF, 32'h0000_0200, 3'd2, 1'b0, 32'h0,        1'b1, 32'h1122_33AA, 4'hF};
        vec[10] = '{1'b1, 4'hC, 32'h0000_0302, 32'hBEEF_0000, 2'd2, 3'd1, 4'h0, 2'b00, 32'h0,        32'h0,        4'hF, 32'h0000_0302, 3'd1, 1'b1, 32'hBEEF_0000, 1'b0, 32'h0,        4'h0};
        vec[11] = '{1'b1, 4'h2, 32'h0000_0401, 32'h0000_5A00, 2'd1, 3'd0, 4'h0, 2'b00, 32'h0,        32'h0,        4'h0, 32'h0000_0401, 3'd0, 1'b1, 32'h0000_5A00, 1'b0, 32'h0,        4'h0};

        idle_inputs();
        wb_allowin = 1'b0;
        rst = 1'b1;
        repeat (3) nxt();
        smp();
        check("rst allowin", 32'(mem_allowin), 32'd1);
        check("rst valid", 32'(mem_to_wb_valid), 32'd0);
        check("rst req", 32'(data_req), 32'd0);
        check("rst addr", data_addr, 32'd0);
        check("rst wdata_wb", RegWdata_MEM_WB, 32'd0);
        check("rst pc", PC_MEM_WB, 32'd0);
        nxt();
        rst = 1'b0;
        smp();
        check("post_rst allowin", 32'(mem_allowin), 32'd1);

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // Stalls on every handshake, then a back-to-back accept from HOLD.
        nxt();
        wb_allowin = 1'b0;
        drive_instr(1'b1, 32'h0000_0500, 4'h0, 2'b11, 5'd3, 32'h0000_1000);
        nxt();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            smp();
            check($sformatf("stall req%0d", k), 32'(data_req), 32'd1);
            check($sformatf("stall addr%0d", k), data_addr, 32'h0000_0500);
            check($sformatf("stall allowin_req%0d", k), 32'(mem_allowin), 32'd0);
            nxt();
        end
        data_addr_ok = 1'b1;
        smp();
        check("stall req_at_ok", 32'(data_req), 32'd1);
        nxt();
        data_addr_ok = 1'b0;
        for (int k = 0; k < 2; k++) begin
            smp();
            check($sformatf("stall resp_req%0d", k), 32'(data_req), 32'd0);
            check($sformatf("stall resp_valid%0d", k), 32'(mem_to_wb_valid), 32'd0);
            check($sformatf("stall resp_allowin%0d", k), 32'(mem_allowin), 32'd0);
            nxt();
        end
        data_data_ok = 1'b1;
        data_rdata   = 32'h0102_0304;
        nxt();
        data_data_ok = 1'b0;
        data_rdata   = 32'hFFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            smp();
            check($sformatf("stall hold_valid%0d", k), 32'(mem_to_wb_valid), 32'd1);
            check($sformatf("stall hold_data%0d", k), RegWdata_MEM_WB, 32'h0102_0304);
            check($sformatf("stall hold_allowin%0d", k), 32'(mem_allowin), 32'd0);
            nxt();
        end
        wb_allowin = 1'b1;
        drive_instr(1'b0, 32'h0000_7777, 4'h0, 2'b00, 5'd9, 32'h0000_1004);
        smp();
        check("stall exit_allowin", 32'(mem_allowin), 32'd1);
        check("stall exit_data", RegWdata_MEM_WB, 32'h0102_0304);
        nxt();
        idle_inputs();
        wb_allowin = 1'b0;
        smp();
        check("b2b valid", 32'(mem_to_wb_valid), 32'd1);
        check("b2b data", RegWdata_MEM_WB, 32'h0000_7777);
        check("b2b waddr", 32'(RegWaddr_MEM_WB), 32'd9);
        nxt();
        wb_allowin = 1'b1;
        nxt();
        smp();
        check("b2b drained", 32'(mem_to_wb_valid), 32'd0);
        check("b2b allowin", 32'(mem_allowin), 32'd1);

        // Flush while waiting for the response: drained silently.
        nxt();
        drive_instr(1'b1, 32'h0000_0600, 4'h0, 2'b11, 5'd4, 32'h0000_2000);
        nxt();
        idle_inputs();
        data_addr_ok = 1'b1;
        nxt();
        data_addr_ok  = 1'b0;
        ex_int_handle = 1'b1;
        smp();
        check("flresp allowin_pulse", 32'(mem_allowin), 32'd0);
        nxt();
        ex_int_handle = 1'b0;
        for (int k = 0; k < 3; k++) begin
            smp();
            check($sformatf("flresp wait_valid%0d", k), 32'(mem_to_wb_valid), 32'd0);
            check($sformatf("flresp wait_allowin%0d", k), 32'(mem_allowin), 32'd0);
            nxt();
        end
        data_data_ok = 1'b1;
        data_rdata   = 32'h5555_5555;
        nxt();
        data_data_ok = 1'b0;
        smp();
        check("flresp valid", 32'(mem_to_wb_valid), 32'd0);
        check("flresp allowin", 32'(mem_allowin), 32'd1);
        // Stray data_ok while empty must not produce a result.
        nxt();
        data_data_ok = 1'b1;
        nxt();
        data_data_ok = 1'b0;
        smp();
        check("stray_ok valid", 32'(mem_to_wb_valid), 32'd0);
        check("stray_ok req", 32'(data_req), 32'd0);

        // Flush in REQ before addr_ok: request withdrawn.
        nxt();
        drive_instr(1'b1, 32'h0000_0700, 4'h8, 2'b00, 5'd5, 32'h0000_3000);
        nxt();
        idle_inputs();
        ex_int_handle = 1'b1;
        smp();
        check("flreq req", 32'(data_req), 32'd1);
        check("flreq allowin", 32'(mem_allowin), 32'd0);
        nxt();
        ex_int_handle = 1'b0;
        smp();
        check("flreq withdrawn", 32'(data_req), 32'd0);
        check("flreq allowin_after", 32'(mem_allowin), 32'd1);

        // Flush coinciding with addr_ok: still waits for data_ok, no result.
        nxt();
        drive_instr(1'b1, 32'h0000_0800, 4'h0, 2'b11, 5'd6, 32'h0000_4000);
        nxt();
        idle_inputs();
        data_addr_ok  = 1'b1;
        ex_int_handle = 1'b1;
        nxt();
        data_addr_ok  = 1'b0;
        ex_int_handle = 1'b0;
        smp();
        check("flok allowin_resp", 32'(mem_allowin), 32'd0);
        data_data_ok = 1'b1;
        nxt();
        data_data_ok = 1'b0;
        smp();
        check("flok valid", 32'(mem_to_wb_valid), 32'd0);
        check("flok allowin", 32'(mem_allowin), 32'd1);

        // Flush while holding a result for a stalled WB.
        nxt();
        wb_allowin = 1'b0;
        drive_instr(1'b0, 32'h0000_0055, 4'h0, 2'b00, 5'd7, 32'h0000_5000);
        nxt();
        idle_inputs();
        ex_int_handle = 1'b1;
        smp();
        check("flhold valid", 32'(mem_to_wb_valid), 32'd1);
        check("flhold allowin", 32'(mem_allowin), 32'd0);
        nxt();
        ex_int_handle = 1'b0;
        smp();
        check("flhold valid_after", 32'(mem_to_wb_valid), 32'd0);
        check("flhold allowin_after", 32'(mem_allowin), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-side bus master for the 5-stage pipeline.
- Accepts one instruction at a time from the EXE/MEM registers.
- For loads and stores, issues one request on the SRAM-like data bus (req / addr_ok / data_ok) and waits for the response.
- For loads, extracts and merges the returned word (LB/LBU/LH/LHU/LW/LWL/LWR) into write-back data. Hands the result to WB under a valid/allowin handshake.

Parameters:
- none (32-bit datapath fixed)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- exe_to_mem_valid  in  1  EXE holds a valid instruction
- mem_allowin  out  1  MEM can accept this cycle
- MemEn_EXE_MEM  in  1  instruction accesses memory
- MemWrite_EXE_MEM  in  4  store byte strobes; nonzero = store
- ALUResult_EXE_MEM  in  32  effective address, or ALU result for non-memory instructions
- MemWdata_EXE_MEM  in  32  lane-aligned store data
- s_vaddr_EXE_MEM  in  2  store address low bits
- s_size_EXE_MEM  in  3  store size (0 = byte, 1 = half, 2 = word, 3 = three bytes)
- LB_EXE_MEM, LBU_EXE_MEM, LH_EXE_MEM, LHU_EXE_MEM  in  1 each  load type
- LW_EXE_MEM  in  2  11 = LW, 10 = LWL, 01 = LWR
- RegRdata2_EXE_MEM  in  32  old rt value, for LWL/LWR merge
- RegWaddr_EXE_MEM  in  5  destination register
- RegWrite_EXE_MEM  in  4  register byte-write enables
- PC_EXE_MEM  in  32  instruction PC
- ex_int_handle  in  1  exception flush
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  3  bus size
- data_addr  out  32  bus address
- data_wdata  out  32  bus write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response / write-complete
- data_rdata  in  32  read word
- wb_allowin  in  1  WB can accept
- mem_to_wb_valid  out  1  result valid
- RegWaddr_MEM_WB  out  5  destination register
- RegWrite_MEM_WB  out  4  register byte-write enables
- RegWdata_MEM_WB  out  32  write-back data
- PC_MEM_WB  out  32  instruction PC

Behaviour:
- States: EMPTY, REQ, RESP, HOLD, plus a sticky cancel flag.
- Reset: state = EMPTY, cancel = 0. All outputs are 0 except mem_allowin = 1.
- mem_allowin = ~ex_int_handle & (EMPTY | (HOLD & wb_allowin)).
- Accept condition: exe_to_mem_valid & mem_allowin.
  - On accept, all inputs are latched.
  - MemEn = 1: next state REQ.
  - MemEn = 0: next state HOLD, RegWdata = ALUResult.
- REQ:
  - data_req = 1.
  - Store: data_wr = 1, data_addr = {ALUResult[31:2], s_vaddr}, data_size = s_size, data_wdata = MemWdata.
  - Load: data_wr = 0, data_addr = {ALUResult[31:2], 2'b00}, data_size = 2, data_wdata = 0.
  - addr_ok: next state RESP. data_req drops the cycle after addr_ok.
- RESP:
  - data_req = 0.
  - data_data_ok: capture the aligned result, next state HOLD.
  - A store goes to HOLD with RegWrite forced to 0.
- HOLD:
  - mem_to_wb_valid = 1.
  - wb_allowin: next state EMPTY, or REQ/HOLD if a new instruction is accepted in the same cycle.
- Minimum load latency: accept edge, REQ with addr_ok, RESP with data_ok, valid in the following cycle (3 cycles after accept).
- Load extraction (v = ALUResult[1:0], W = data_rdata, R = RegRdata2):
  - LB: sign-extend byte v. LBU: zero-extend byte v.
  - LH: sign-extend half v[1]. LHU: zero-extend half v[1].
  - LW: W.
  - LWL: v = 0 gives {W[7:0], R[23:0]}; v = 1 gives {W[15:0], R[15:0]}; v = 2 gives {W[23:0], R[7:0]}; v = 3 gives W.
  - LWR: v = 0 gives W; v = 1 gives {R[31:24], W[31:8]}; v = 2 gives {R[31:16], W[31:16]}; v = 3 gives {R[31:8], W[31:24]}.
- Flush (ex_int_handle = 1):
  - EMPTY: no accept.
  - REQ without addr_ok: go to EMPTY, data_req withdrawn next cycle.
  - REQ with addr_ok: go to RESP with cancel = 1.
  - RESP: cancel = 1.
  - HOLD: go to EMPTY, mem_to_wb_valid = 0 next cycle.
- Cancelled RESP:
  - Still waits for data_ok, since an accepted transaction is never abandoned. mem_allowin = 0.
  - On data_ok: go to EMPTY, cancel = 0, no result emitted.
- data_data_ok outside RESP is ignored.
- addr_ok outside REQ is ignored.
- A reset mid-transaction returns to EMPTY immediately; any bus response still in flight is not tracked.

Test Plan:
- ALU pass-through: accept MemEn = 0, ALUResult = 0x1234, wb_allowin = 1 -> valid next cycle, RegWdata = 0x1234, data_req never asserted.
- LB sign: addr 0x103, rdata = 0x80FF_0000, addr_ok and data_ok one cycle each -> data_addr = 0x100, size = 2, RegWdata = 0xFFFF_FF80. Same case with LBU -> 0x0000_0080.
- LWL/LWR: addr 0x201, W = 0xAABBCCDD, R = 0x11223344 -> LWL gives 0xCCDD3344, LWR gives 0x11AABBCC.
- Store SH: addr 0x302, MemWdata = 0xBEEF0000, s_vaddr = 2, s_size = 1 -> data_wr = 1, data_addr = 0x302, size = 1, wdata = 0xBEEF0000. After data_ok, RegWrite_MEM_WB = 0.
- Stalls: addr_ok delayed 3 cycles, data_ok 2 more, wb_allowin low 2 cycles -> data_req held steady, mem_allowin = 0 until the HOLD exit, outputs stable.
- Flush after addr_ok: ex_int_handle pulses in RESP, data_ok arrives 4 cycles later -> mem_to_wb_valid stays 0, state returns to EMPTY, mem_allowin = 1 the following cycle.
